blk_collect: RTL and testbench
==============================

BLK_COLLECT -- requirements
Module: blk_collect

Interface
REQ-001 SHALL have parameter NCH, default 16, meaning the number of channel ports (1..64).
REQ-002 SHALL have port clk, input, 1 bit: the 125 MHz clock; every register is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port req, input, NCH bits: per-channel request; high means at least one complete block is pending.
REQ-005 SHALL have port din, input, 16*NCH bits: per-channel data; slice k is [16k+15:16k].
REQ-006 SHALL have port ack, output, NCH bits: per-channel acknowledge; at most one bit high at any time.
REQ-007 SHALL have port oafull, input, 1 bit: downstream almost-full flag, guaranteeing room for at least 257 words.
REQ-008 SHALL have port odata, output, 16 bits: forwarded word.
REQ-009 SHALL have output ports ovalid, osop, oeop, 1 bit each: word valid, first word of block, last word of block.
REQ-010 SHALL have port ochan, output, 6 bits: port index of the block being forwarded.
REQ-011 SHALL have port err, output, 1 bit: single-cycle pulse on a header check failure.

Function
REQ-012 Channel protocol: a word acked in cycle t SHALL be taken from din[k] in cycle t+1.
REQ-013 Block length: header[7:0] = L; header[15:14]=2'b10 (self trigger) gives N=1+L words; 2'b11 (master trigger) gives N=2+L words.
REQ-014 States SHALL be IDLE, HDRACK, HDRWAIT, BODY.
REQ-015 IDLE: when !oafull and any req is set, select channel k round-robin, starting the search at last_served+1 and wrapping at NCH-1 to 0; go to HDRACK.
REQ-016 HDRACK: assert ack[k] for exactly 1 cycle; go to HDRWAIT.
REQ-017 HDRWAIT: ack low; decode the header from din[k] and load remaining = N-1 (9 bits); go to BODY if N>1, else to IDLE.
REQ-018 BODY: assert ack[k] for exactly remaining consecutive cycles, ignoring req; go to IDLE after the last ack; set last_served = k.
REQ-019 req SHALL be sampled only in IDLE; a channel deasserting req mid-block SHALL NOT shorten the block.
REQ-020 Forwarding: each received word SHALL appear on odata with ovalid=1 one cycle after it is on din.
  - osop accompanies the header.
  - oeop accompanies word N; for N=1, osop and oeop are set together.
  - ochan = k for the whole block.
REQ-021 Throughput: at most 1 word/clk; per-block overhead is 2 idle ack cycles.
REQ-022 oafull SHALL gate only the start of a new block and never interrupt one in progress.
REQ-023 A header with bit15=0 SHALL be treated as a master block of length L (no recovery is attempted).

Reset
REQ-024 On rst, ack, ovalid, osop, oeop and err SHALL be 0; odata and ochan SHALL be 0; state SHALL be IDLE; last_served SHALL be NCH-1.
REQ-025 rst asserted mid-block SHALL drop ack immediately (asynchronously); no partial-block recovery is done.

Configuration
REQ-026 With macro BLK_COLLECT_HDRCHK_EN defined: in HDRWAIT, a header with bit15=0, or with header[13:8] != k, SHALL pulse err for 1 cycle.
  - The block is still read and forwarded in full.
  - A 16-bit saturating error counter SHALL be readable on port errcnt.
REQ-027 Without BLK_COLLECT_HDRCHK_EN: err SHALL be tied to 0, errcnt SHALL be absent, and no comparison logic SHALL exist.

Structure
REQ-028 Package wfd_blk_pkg SHALL hold the signature codes (SIG_SELF=2'b10, SIG_MAST=2'b11), the header field positions and the state encoding.
REQ-029 Sub-module rr_pick (parameter NCH; inputs req and last; outputs grant index and any) SHALL implement the round-robin search.

Verification
REQ-030 The bench SHALL cover these scenarios:
  - ch3 holds self block 0x8308 plus 8 data words: 9 ovalid words, osop on 0x8308, oeop on word 9, ochan=3, ack[3] high for 1+8 cycles.
  - ch0 holds master block 0xC004, 0x8123, 4 data words: N=6 forwarded, the trigger word 0x8123 is second.
  - Self header 0x8500 (L=0) on ch5: a single word with osop=oeop=1; ack[5] high for 1 cycle only.
  - req = all ones with last_served=2: service order 3,4,...,NCH-1,0,1,2.
  - oafull=1 during BODY: the block completes; no next HDRACK until oafull=0.
  - With BLK_COLLECT_HDRCHK_EN, header 0x8708 on ch2: err pulses once, errcnt=1, 9 words forwarded.
  - rst pulsed at BODY word 3: ack=0 and ovalid=0 immediately; state IDLE after release.

Source files
------------

// File: rtl/wfd_blk_pkg.sv
// wfd_blk_pkg: shared header layout, signature codes and FSM encoding for blk_collect.
package wfd_blk_pkg;
    localparam logic [1:0] SIG_SELF = 2'b10;
    localparam logic [1:0] SIG_MAST = 2'b11;
    localparam int HDR_SIG_LSB = 14;
    localparam int HDR_CH_MSB  = 13;
    localparam int HDR_CH_LSB  = 8;
    localparam int HDR_LEN_MSB = 7;
    typedef enum logic [1:0] {IDLE, HDRACK, HDRWAIT, BODY} state_t;
    // Words still to fetch after the header (N-1); non-self signatures count as master.
    function automatic logic [8:0] hdr_rem(input logic [15:0] hdr);
        return hdr[HDR_SIG_LSB +: 2] == SIG_SELF ? {1'b0, hdr[HDR_LEN_MSB:0]}
                                                 : {1'b0, hdr[HDR_LEN_MSB:0]} + 9'd1;
    endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: round-robin channel search starting after the last served channel.
module rr_pick #(
    parameter int NCH = 16
) (
    input  logic [NCH-1:0] req,
    input  logic [5:0]     last,
    output logic [5:0]     grant,
    output logic           any
);
    assign any = |req;
    always_comb begin
        grant = last;
        for (int i = NCH; i >= 1; i--)
            if (|(req & (NCH'(1) << ((int'(last) + i) % NCH)))) grant = 6'((int'(last) + i) % NCH);
    end
endmodule

// File: rtl/blk_collect.sv
// blk_collect: round-robin block collector forwarding one channel's block at a time.
// Optional header check (err pulse, errcnt port) enabled by BLK_COLLECT_HDRCHK_EN.
module blk_collect import wfd_blk_pkg::*; #(
    parameter int NCH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    req,
    input  logic [16*NCH-1:0] din,
    output logic [NCH-1:0]    ack,
    input  logic              oafull,
    output logic [15:0]       odata,
    output logic              ovalid,
    output logic              osop,
    output logic              oeop,
    output logic [5:0]        ochan,
    output logic              err
`ifdef BLK_COLLECT_HDRCHK_EN
    ,
    output logic [15:0]       errcnt
`endif
);
    state_t      state, nxt;
    logic [5:0]  chan, last, grant;
    logic [8:0]  rem, hrem;
    logic [15:0] hdr;
    logic        any, go, act, take, fin;

    rr_pick #(.NCH(NCH)) u_pick (.req(req), .last(last), .grant(grant), .any(any));

    assign hdr  = 16'(din >> {chan, 4'b0});
    assign hrem = hdr_rem(hdr);
    assign go   = !oafull && any;
    // ack is decoded from the state register so an async reset drops it at once
    assign act  = state == HDRACK || state == BODY;
    assign ack  = act ? NCH'(1) << chan : '0;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = go ? HDRACK : IDLE;
            HDRACK:  nxt = HDRWAIT;
            HDRWAIT: nxt = hrem == 9'd0 ? IDLE : BODY;
            BODY:    nxt = rem == 9'd1 ? IDLE : BODY;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            chan   <= '0;
            last   <= 6'(NCH - 1);
            rem    <= '0;
            take   <= 1'b0;
            fin    <= 1'b0;
            odata  <= '0;
            ovalid <= 1'b0;
            osop   <= 1'b0;
            oeop   <= 1'b0;
            ochan  <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE && go) chan <= grant;
            if (state == HDRWAIT) rem <= hrem;
            else if (state == BODY) rem <= rem - 9'd1;
            if ((state == HDRWAIT && hrem == 9'd0) || (state == BODY && rem == 9'd1)) last <= chan;
            // take marks the cycle after an ack, when din carries the requested word
            take   <= act;
            fin    <= state == BODY && rem == 9'd1;
            ovalid <= take;
            osop   <= take && state == HDRWAIT;
            oeop   <= take && (state == HDRWAIT ? hrem == 9'd0 : fin);
            if (take) begin
                odata <= hdr;
                ochan <= chan;
            end
        end
    end

`ifdef BLK_COLLECT_HDRCHK_EN
    logic chk;
    assign chk = state == HDRWAIT && (!hdr[15] || hdr[HDR_CH_MSB:HDR_CH_LSB] != chan);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err    <= 1'b0;
            errcnt <= '0;
        end else begin
            err    <= chk;
            errcnt <= errcnt + 16'(chk && errcnt != 16'hFFFF);
        end
    end
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_blk_collect.sv
// tb_blk_collect: directed scenarios with channel models and an output scoreboard.
module tb_blk_collect;
    localparam int NCH = 16;
`ifdef BLK_COLLECT_HDRCHK_EN
    localparam int EXP_ERR = 1;
`else
    localparam int EXP_ERR = 0;
`endif

    logic              clk = 1'b0, rst = 1'b1, oafull = 1'b0;
    logic [NCH-1:0]    req = '0, ack, ack_s = '0;
    logic [16*NCH-1:0] din = '0;
    logic [15:0]       odata;
    logic              ovalid, osop, oeop, err;
    logic [5:0]        ochan;
`ifdef BLK_COLLECT_HDRCHK_EN
    logic [15:0]       errcnt;
`endif

    int tests = 0, fails = 0, errs = 0, bad_hot = 0;
    int acks [NCH];
    logic [15:0] cq [NCH][$];
    logic [23:0] sb [$];

    always #4 clk = ~clk;

    blk_collect #(.NCH(NCH)) dut (
        .clk(clk), .rst(rst), .req(req), .din(din), .ack(ack), .oafull(oafull),
        .odata(odata), .ovalid(ovalid), .osop(osop), .oeop(oeop), .ochan(ochan), .err(err)
`ifdef BLK_COLLECT_HDRCHK_EN
        , .errcnt(errcnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial for (int k = 0; k < NCH; k++) acks[k] = 0;

    // Monitor: ack bookkeeping and scoreboard comparison away from the rising edge
    always @(negedge clk) begin
        ack_s = ack;
        if (err === 1'b1) errs++;
        if (!$onehot0(ack)) bad_hot++;
        for (int k = 0; k < NCH; k++) if (ack[k] === 1'b1) acks[k]++;
        if (ovalid === 1'b1) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) chk("word", {8'h0, ochan, osop, oeop, odata}, {8'h0, sb.pop_front()});
        end
    end

    // Channel model: a word acked in cycle t is presented in cycle t+1
    always @(posedge clk) begin
        #1;
        for (int k = 0; k < NCH; k++) begin
            if (ack_s[k] && cq[k].size() != 0) din[16*k +: 16] = cq[k].pop_front();
            req[k] = cq[k].size() != 0;
        end
    end

    task automatic load(input int k, input logic [15:0] w[$]);
        for (int i = 0; i < w.size(); i++) begin
            cq[k].push_back(w[i]);
            sb.push_back({6'(k), 1'(i == 0), 1'(i == w.size() - 1), w[i]});
        end
    endtask

    task automatic blk(input int k, input logic [15:0] hdr, input int nd);
        logic [15:0] q[$];
        q.push_back(hdr);
        for (int i = 0; i < nd; i++) q.push_back(16'(16'h1000 + k * 256 + i));
        load(k, q);
    endtask

    task automatic drain(input int left, input string tag);
        int n = 0;
        while (sb.size() > left && n < 2000) begin
            @(negedge clk); #1;
            n++;
        end
        chk(tag, sb.size(), left);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [15:0] q[$];
        int a, b, n;
        repeat (3) @(negedge clk);
        chk("rst_ack", ack, 0);
        chk("rst_ovalid", ovalid, 0);
        chk("rst_osop", osop, 0);
        chk("rst_oeop", oeop, 0);
        chk("rst_odata", odata, 0);
        chk("rst_ochan", ochan, 0);
        chk("rst_err", err, 0);
`ifdef BLK_COLLECT_HDRCHK_EN
        chk("rst_errcnt", errcnt, 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        a = acks[3];
        blk(3, 16'h8308, 8);
        drain(0, "s1_drain");
        chk("s1_ack3", acks[3] - a, 9);

        a = acks[0];
        q = {16'hC004, 16'h8123, 16'h0B00, 16'h0B01, 16'h0B02, 16'h0B03};
        load(0, q);
        drain(0, "s2_drain");
        chk("s2_ack0", acks[0] - a, 6);

        a = acks[5];
        blk(5, 16'h8500, 0);
        drain(0, "s3_drain");
        chk("s3_ack5", acks[5] - a, 1);

        blk(2, 16'h8200, 0);
        drain(0, "s4_pre");
        for (int i = 1; i <= NCH; i++) blk((2 + i) % NCH, 16'(16'h8000 + ((2 + i) % NCH) * 256), 0);
        drain(0, "s4_rr_drain");

        a = acks[1];
        b = acks[4];
        blk(4, 16'h8406, 6);
        blk(1, 16'h8102, 2);
        n = 0;
        while (acks[4] == b && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        chk("s5_start", 32'(acks[4] > b), 1);
        repeat (2) @(negedge clk);
        oafull = 1'b1;
        drain(3, "s5_first");
        repeat (10) @(negedge clk);
        chk("s5_hold_ack1", acks[1] - a, 0);
        chk("s5_hold_sb", sb.size(), 3);
        oafull = 1'b0;
        drain(0, "s5_drain");
        chk("s5_ack4", acks[4] - b, 7);
        chk("s5_ack1", acks[1] - a, 3);

        a = errs;
        blk(2, 16'h8708, 8);
        drain(0, "s6_drain");
        chk("s6_err", errs - a, EXP_ERR);
`ifdef BLK_COLLECT_HDRCHK_EN
        chk("s6_errcnt", errcnt, 1);
`endif

        a = acks[6];
        blk(6, 16'h8608, 8);
        n = 0;
        while (acks[6] - a < 4 && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        chk("s7_reach", 32'(acks[6] - a >= 4), 1);
        rst = 1'b1;
        #1;
        chk("s7_rst_ack", ack, 0);
        chk("s7_rst_ovalid", ovalid, 0);
        cq[6].delete();
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("s7_idle_ack", ack, 0);
        chk("s7_idle_ovalid", ovalid, 0);
        a = acks[7];
        blk(7, 16'h8700, 0);
        drain(0, "s7_after");
        chk("s7_ack7", acks[7] - a, 1);

        chk("err_total", errs, EXP_ERR);
        chk("ack_onehot", bad_hot, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
